// File: rtl/lcd_pkg.sv
// Shared types and IRQ bit positions for the LCD frame scheduler slice.
// No logic; no flow control.
package lcd_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } flip_state_t;

   localparam int IRQ_BITS  = 3;
   localparam int IRQ_FLIP  = 0;
   localparam int IRQ_FRAME = 1;
   localparam int IRQ_ROW   = 2;

endpackage

// File: rtl/lcd_irq_status.sv
// Sticky N-bit interrupt status with per-bit ack and a registered masked IRQ line.
// Status updates one cycle after set/ack; IRQ follows status by one more cycle; no backpressure.
module lcd_irq_status #(
   parameter int N = 3
) (
   input  logic         CLK_PXCLK,
   input  logic         RESET,
   input  logic [N-1:0] set,
   input  logic [N-1:0] ack,
   input  logic [N-1:0] mask,
   output logic [N-1:0] status,
   output logic         irq
);

   always_ff @(posedge CLK_PXCLK) begin
      if (RESET) begin
         status <= '0;
         irq    <= 1'b0;
      end else begin
         // a set arriving with its ack wins, so no event is lost
         status <= (status & ~ack) | set;
         irq    <= |(status & mask);
      end
   end

endmodule

// File: rtl/lcd_frame_scheduler.sv
// Owns the DMA frame-buffer base: double-buffer flips commit only at AFTER_FRAME; counts frames and raises IRQs.
// Flip/flag outputs are registered (1-cycle latency); no backpressure, a newer pending flip replaces the older one.
module lcd_frame_scheduler
   import lcd_pkg::*;
#(
   parameter int                   ADDR_BITS      = 29,
   parameter int                   Y_BITS         = 9,
   parameter int                   FRAME_CNT_BITS = 16,
   parameter logic [ADDR_BITS-1:0] DEFAULT_ADDR   = '0
) (
   input  logic                      CLK_PXCLK,
   input  logic                      RESET,
   input  logic                      BEFORE_FRAME,
   input  logic                      AFTER_FRAME,
   input  logic [Y_BITS-1:0]         ROW_INDEX,
   input  logic                      FLIP_REQ,
   input  logic [ADDR_BITS-1:0]      FLIP_ADDR,
   input  logic [Y_BITS-1:0]         ROW_MATCH,
   input  logic [2:0]                IRQ_MASK,
   input  logic [2:0]                IRQ_ACK,
   output logic [ADDR_BITS-1:0]      ACTIVE_ADDR,
   output logic                      FLIP_PENDING,
   output logic                      FLIP_DONE,
   output logic                      FLIP_DROPPED,
   output logic                      IN_FRAME,
   output logic [FRAME_CNT_BITS-1:0] FRAME_COUNT,
   output logic [2:0]                IRQ_STATUS,
   output logic                      IRQ
);

   flip_state_t          state_q, state_d;
   logic [ADDR_BITS-1:0] pend_addr;
   logic [Y_BITS-1:0]    row_prev;
   logic                 latch, commit, drop;
   logic                 row_hit;
   logic [IRQ_BITS-1:0]  irq_set;

   always_ff @(posedge CLK_PXCLK) begin
      if (RESET) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      latch   = 1'b0;
      commit  = 1'b0;
      drop    = 1'b0;
      case (state_q)
         IDLE: begin
            // a request on the boundary itself waits for the next boundary
            if (FLIP_REQ) begin
               latch   = 1'b1;
               state_d = PENDING;
            end
         end
         PENDING: begin
            if (AFTER_FRAME) begin
               commit = 1'b1;
               if (FLIP_REQ) latch   = 1'b1;
               else          state_d = IDLE;
            end else if (FLIP_REQ) begin
               latch = 1'b1;
               drop  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_PXCLK) begin
      if (RESET) begin
         pend_addr    <= '0;
         ACTIVE_ADDR  <= DEFAULT_ADDR;
         FLIP_PENDING <= 1'b0;
         FLIP_DONE    <= 1'b0;
         FLIP_DROPPED <= 1'b0;
      end else begin
         if (commit) ACTIVE_ADDR <= pend_addr;
         if (latch)  pend_addr   <= FLIP_ADDR;
         FLIP_PENDING <= (state_d == PENDING);
         FLIP_DONE    <= commit;
         FLIP_DROPPED <= drop;
      end
   end

   always_ff @(posedge CLK_PXCLK) begin
      if (RESET) begin
         IN_FRAME    <= 1'b0;
         FRAME_COUNT <= '0;
         row_prev    <= '0;
      end else begin
         if (AFTER_FRAME)       IN_FRAME <= 1'b0;
         else if (BEFORE_FRAME) IN_FRAME <= 1'b1;
         if (AFTER_FRAME) FRAME_COUNT <= FRAME_COUNT + FRAME_CNT_BITS'(1);
         row_prev <= ROW_INDEX;
      end
   end

   // edge-qualified so the row IRQ fires once on entry to the row, not every cycle on it
   assign row_hit = (ROW_INDEX == ROW_MATCH) && (ROW_INDEX != row_prev);

   always_comb begin
      irq_set            = '0;
      irq_set[IRQ_FLIP]  = commit;
      irq_set[IRQ_FRAME] = AFTER_FRAME;
      irq_set[IRQ_ROW]   = row_hit;
   end

   lcd_irq_status #(.N(IRQ_BITS)) u_irq_status (
      .CLK_PXCLK (CLK_PXCLK),
      .RESET     (RESET),
      .set       (irq_set),
      .ack       (IRQ_ACK),
      .mask      (IRQ_MASK),
      .status    (IRQ_STATUS),
      .irq       (IRQ)
   );

endmodule
